alu_exec_md: RTL and testbench

//  Next-generation EXECUTE-stage ALU: decodes ALUOp/funct (same ALUCtrl codes as the current decoder) and executes the operation.

---
 rtl/alu_exec_md.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_alu_exec_md.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_md.sv
// alu_exec_md: EXECUTE-stage ALU with ALUOp/funct decode, iterative
// MULT/MULTU/DIV/DIVU on a shared shift register, and architectural HI/LO.
// A valid/ready handshake stalls the pipeline while a multi-cycle op runs.
// Optional divider: define ALU_MULDIV_DIV_EN to build DIV/DIVU; without it
// those funct codes decode as illegal and div_by_zero is tied low.

module alu_exec_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    // Lower codes match the existing ALU decoder; upper codes are internal.
    typedef enum logic [3:0] {
        CTRL_AND   = 4'b0000,
        CTRL_OR    = 4'b0001,
        CTRL_ADD   = 4'b0010,
        CTRL_SUB   = 4'b0110,
        CTRL_SLT   = 4'b0111,
        CTRL_MULT  = 4'b1000,
        CTRL_MULTU = 4'b1001,
        CTRL_DIV   = 4'b1010,
        CTRL_DIVU  = 4'b1011,
        CTRL_MFHI  = 4'b1100,
        CTRL_MFLO  = 4'b1101,
        CTRL_ILL   = 4'b1111
    } aluCtrl_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

    state_e                 r_state;
    state_e                 w_nextState;
    aluCtrl_e               w_ctrl;
    logic                   w_accept;
    logic                   w_isMul;
    logic                   w_isDiv;
    logic                   w_signedOp;
    logic [WIDTH-1:0]       w_aMag;
    logic [WIDTH-1:0]       w_bMag;
    logic [WIDTH-1:0]       w_aluRes;
    logic [CW-1:0]          r_count;
    logic [WIDTH-1:0]       r_pHi;
    logic [WIDTH-1:0]       r_pLo;
    logic [WIDTH-1:0]       r_mcand;
    logic                   r_negLo;
    logic [WIDTH:0]         w_mulSum;
    logic [2*WIDTH-1:0]     w_prod;
    logic [2*WIDTH-1:0]     w_prodNeg;
    logic [WIDTH-1:0]       w_fixHi;
    logic [WIDTH-1:0]       w_fixLo;

`ifdef ALU_MULDIV_DIV_EN
    logic                   w_bZero;
    logic [WIDTH:0]         w_divShift;
    logic [WIDTH-1:0]       w_divDiff;
    logic                   w_divBit;
    logic [WIDTH-1:0]       w_divRem;
    logic                   r_negHi;
    logic                   r_isDivOp;
    logic                   r_divZero;
    logic [WIDTH-1:0]       r_opA;
`endif

    // Translate ALUOp/funct into an internal control code.
    always_comb begin
        w_ctrl = CTRL_ILL;
        case (ALUOp)
            2'b00: w_ctrl = CTRL_ADD;
            2'b01: w_ctrl = CTRL_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: w_ctrl = CTRL_ADD;
                    6'b100010: w_ctrl = CTRL_SUB;
                    6'b100100: w_ctrl = CTRL_AND;
                    6'b100101: w_ctrl = CTRL_OR;
                    6'b101010: w_ctrl = CTRL_SLT;
                    6'b011000: w_ctrl = CTRL_MULT;
                    6'b011001: w_ctrl = CTRL_MULTU;
`ifdef ALU_MULDIV_DIV_EN
                    6'b011010: w_ctrl = CTRL_DIV;
                    6'b011011: w_ctrl = CTRL_DIVU;
`endif
                    6'b010000: w_ctrl = CTRL_MFHI;
                    6'b010010: w_ctrl = CTRL_MFLO;
                    default:   w_ctrl = CTRL_ILL;
                endcase
            end
            default: w_ctrl = CTRL_ILL;
        endcase
    end

    assign w_accept   = valid_in && ready;
    assign w_isMul    = (w_ctrl == CTRL_MULT) || (w_ctrl == CTRL_MULTU);
    assign w_signedOp = (w_ctrl == CTRL_MULT) || (w_ctrl == CTRL_DIV);
`ifdef ALU_MULDIV_DIV_EN
    assign w_isDiv    = (w_ctrl == CTRL_DIV) || (w_ctrl == CTRL_DIVU);
    assign w_bZero    = (b == '0);
`else
    assign w_isDiv    = 1'b0;
`endif

    // Iterations run on magnitudes; the most-negative value maps onto itself,
    // which is already its correct unsigned magnitude.
    assign w_aMag = (w_signedOp && a[WIDTH-1]) ? (-a) : a;
    assign w_bMag = (w_signedOp && b[WIDTH-1]) ? (-b) : b;

    // Single-cycle result; MFHI/MFLO read the committed HI/LO registers.
    always_comb begin
        w_aluRes = '0;
        case (w_ctrl)
            CTRL_ADD:  w_aluRes = a + b;
            CTRL_SUB:  w_aluRes = a - b;
            CTRL_AND:  w_aluRes = a & b;
            CTRL_OR:   w_aluRes = a | b;
            CTRL_SLT:  w_aluRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            CTRL_MFHI: w_aluRes = hi;
            CTRL_MFLO: w_aluRes = lo;
            default:   w_aluRes = '0;
        endcase
    end

    // One shift-add step: add the multiplicand when the low bit is set, then
    // shift the whole {carry, hi, lo} product right by one.
    assign w_mulSum = {1'b0, r_pHi} + (r_pLo[0] ? {1'b0, r_mcand} : '0);

`ifdef ALU_MULDIV_DIV_EN
    // One restoring-divide step: bring the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The remainder stays
    // below the divisor, so the low WIDTH bits of the difference are exact.
    assign w_divShift = {r_pHi, r_pLo[WIDTH-1]};
    assign w_divBit   = (w_divShift >= {1'b0, r_mcand});
    assign w_divDiff  = w_divShift[WIDTH-1:0] - r_mcand;
    assign w_divRem   = w_divBit ? w_divDiff : w_divShift[WIDTH-1:0];
`endif

    assign w_prod    = {r_pHi, r_pLo};
    assign w_prodNeg = -w_prod;

    // Sign correction and special cases applied while in FIX.
    always_comb begin
        {w_fixHi, w_fixLo} = r_negLo ? w_prodNeg : w_prod;
`ifdef ALU_MULDIV_DIV_EN
        if (r_isDivOp) begin
            if (r_divZero) begin
                w_fixHi = r_opA;
                w_fixLo = '1;
            end else begin
                w_fixLo = r_negLo ? (-r_pLo) : r_pLo;
                w_fixHi = r_negHi ? (-r_pHi) : r_pHi;
            end
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: a zero divisor skips the iterations entirely.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_isMul) begin
                    w_nextState = S_MUL;
                end
`ifdef ALU_MULDIV_DIV_EN
                else if (w_accept && w_isDiv) begin
                    w_nextState = w_bZero ? S_FIX : S_DIV;
                end
`endif
            end
            S_MUL:   if (r_count == '0) w_nextState = S_FIX;
            S_DIV:   if (r_count == '0) w_nextState = S_FIX;
            S_FIX:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Handshake output: only IDLE takes new work, including the completion cycle.
    always_comb begin
        ready = (r_state == S_IDLE);
    end

    // Iteration datapath: loads magnitudes on accept and steps once per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_pHi   <= '0;
            r_pLo   <= '0;
            r_mcand <= '0;
            r_negLo <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_isMul) begin
                        r_count <= CW'(WIDTH - 1);
                        r_pHi   <= '0;
                        r_pLo   <= w_bMag;
                        r_mcand <= w_aMag;
                        r_negLo <= w_signedOp & (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
`ifdef ALU_MULDIV_DIV_EN
                    else if (w_accept && w_isDiv) begin
                        r_count <= CW'(WIDTH - 1);
                        r_pHi   <= '0;
                        r_pLo   <= w_aMag;
                        r_mcand <= w_bMag;
                        r_negLo <= w_signedOp & (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
`endif
                end
                S_MUL: begin
                    r_pHi <= w_mulSum[WIDTH:1];
                    r_pLo <= {w_mulSum[0], r_pLo[WIDTH-1:1]};
                    if (r_count != '0) r_count <= r_count - CW'(1);
                end
`ifdef ALU_MULDIV_DIV_EN
                S_DIV: begin
                    r_pHi <= w_divRem;
                    r_pLo <= {r_pLo[WIDTH-2:0], w_divBit};
                    if (r_count != '0) r_count <= r_count - CW'(1);
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef ALU_MULDIV_DIV_EN
    // Divide bookkeeping captured at accept: remainder sign, zero divisor, raw dividend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_negHi   <= 1'b0;
            r_isDivOp <= 1'b0;
            r_divZero <= 1'b0;
            r_opA     <= '0;
        end else if (w_accept && (w_isMul || w_isDiv)) begin
            r_negHi   <= w_signedOp & a[WIDTH-1];
            r_isDivOp <= w_isDiv;
            r_divZero <= w_isDiv & w_bZero;
            r_opA     <= a;
        end
    end

    // Divide-by-zero flag changes only when a divide completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_by_zero <= 1'b0;
        end else if ((r_state == S_FIX) && r_isDivOp) begin
            div_by_zero <= r_divZero;
        end
    end
`else
    assign div_by_zero = 1'b0;
`endif

    // Registered results: FIX commits HI/LO, single-cycle ops respond on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            valid_out <= 1'b0;
            if (r_state == S_FIX) begin
                valid_out <= 1'b1;
                result    <= w_fixLo;
                zero      <= (w_fixLo == '0);
                illegal   <= 1'b0;
                hi        <= w_fixHi;
                lo        <= w_fixLo;
            end else if (w_accept && !w_isMul && !w_isDiv) begin
                valid_out <= 1'b1;
                result    <= w_aluRes;
                zero      <= (w_aluRes == '0);
                illegal   <= (w_ctrl == CTRL_ILL);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_md.sv
// tb_alu_exec_md: directed bench for alu_exec_md (WIDTH=32) with a
// scoreboard of expected results produced by a behavioural model.
// Honours ALU_MULDIV_DIV_EN the same way the design does.

module tb_alu_exec_md;

    logic        clock;
    logic        reset;
    logic        validIn;
    logic        ready;
    logic [1:0]  aluOp;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        validOut;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        divByZero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
        logic        ill;
        logic        dbz;
        logic [31:0] lat;
    } exp_t;

    exp_t        expQ[$];
    string       tagQ[$];
    logic [31:0] mHi;
    logic [31:0] mLo;
    logic        mDbz;
    int          compCount;
    int          errCount;

    alu_exec_md #(.WIDTH(32)) dut (
        .clk        (clock),
        .rst        (reset),
        .valid_in   (validIn),
        .ready      (ready),
        .ALUOp      (aluOp),
        .funct      (funct),
        .a          (a),
        .b          (b),
        .valid_out  (validOut),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal),
        .div_by_zero(divByZero),
        .hi         (hi),
        .lo         (lo)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural reference: updates the HI/LO/flag model and returns the expected response.
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                   input logic [31:0] av, input logic [31:0] bv);
        exp_t               e;
        logic [31:0]        res;
        logic               ill;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic [63:0]        up;
        bit                 divEn;
`ifdef ALU_MULDIV_DIV_EN
        divEn = 1'b1;
`else
        divEn = 1'b0;
`endif
        sa = $signed(av);
        sb = $signed(bv);
        res = 32'h0;
        ill = 1'b0;
        e.lat = 32'd1;
        if (op == 2'b00) begin
            res = av + bv;
        end else if (op == 2'b01) begin
            res = av - bv;
        end else if (op == 2'b10) begin
            case (fn)
                6'b100000: res = av + bv;
                6'b100010: res = av - bv;
                6'b100100: res = av & bv;
                6'b100101: res = av | bv;
                6'b101010: res = (sa < sb) ? 32'd1 : 32'd0;
                6'b011000: begin
                    sp = sa * sb;
                    mHi = sp[63:32];
                    mLo = sp[31:0];
                    res = mLo;
                    e.lat = 32'd34;
                end
                6'b011001: begin
                    up = {32'h0, av} * {32'h0, bv};
                    mHi = up[63:32];
                    mLo = up[31:0];
                    res = mLo;
                    e.lat = 32'd34;
                end
                6'b011010, 6'b011011: begin
                    if (!divEn) begin
                        ill = 1'b1;
                    end else if (bv == 32'h0) begin
                        mHi = av;
                        mLo = 32'hFFFF_FFFF;
                        mDbz = 1'b1;
                        res = mLo;
                        e.lat = 32'd2;
                    end else begin
                        if (fn == 6'b011010) begin
                            sp = sa / sb;
                            mLo = sp[31:0];
                            sp = sa % sb;
                            mHi = sp[31:0];
                        end else begin
                            mLo = av / bv;
                            mHi = av % bv;
                        end
                        mDbz = 1'b0;
                        res = mLo;
                        e.lat = 32'd34;
                    end
                end
                6'b010000: res = mHi;
                6'b010010: res = mLo;
                default:   ill = 1'b1;
            endcase
        end else begin
            ill = 1'b1;
        end
        if (ill) res = 32'h0;
        e.res  = res;
        e.zero = (res == 32'h0);
        e.ill  = ill;
        e.hi   = mHi;
        e.lo   = mLo;
        e.dbz  = mDbz;
        return e;
    endfunction

    // Single comparison point.
    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pops the oldest expectation and compares it against the current outputs.
    task automatic checkOutput(input int n);
        exp_t  e;
        string t;
        if (expQ.size() == 0) begin
            compCount++;
            errCount++;
            $error("[TB] FAIL scoreboard: observed a response, expected a pending entry");
        end else begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkEq({t, "_lat"},    32'(n),         e.lat);
            checkEq({t, "_vout"},   32'(validOut),  32'd1);
            checkEq({t, "_result"}, result,         e.res);
            checkEq({t, "_zero"},   32'(zero),      32'(e.zero));
            checkEq({t, "_ill"},    32'(illegal),   32'(e.ill));
            checkEq({t, "_dbz"},    32'(divByZero), 32'(e.dbz));
            checkEq({t, "_hi"},     hi,             e.hi);
            checkEq({t, "_lo"},     lo,             e.lo);
        end
    endtask

    // Presents one op for a single accepting edge and waits (bounded) for its response.
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        int   n;
        @(negedge clock);
        aluOp = op;
        funct = fn;
        a = av;
        b = bv;
        validIn = 1'b1;
        e = model(op, fn, av, bv);
        expQ.push_back(e);
        tagQ.push_back(tag);
        @(posedge clock);
        #1;
        n = 1;
        validIn = 1'b0;
        checkEq({tag, "_ready"}, 32'(ready), 32'(e.lat == 32'd1));
        while (!validOut && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput(n);
    endtask

    // Directed sequence.
    initial begin
        exp_t e;
        int   n;
        compCount = 0;
        errCount = 0;
        mHi = 32'h0;
        mLo = 32'h0;
        mDbz = 1'b0;
        reset = 1'b1;
        validIn = 1'b0;
        aluOp = 2'b00;
        funct = 6'h0;
        a = 32'h0;
        b = 32'h0;

        repeat (2) @(posedge clock);
        #1;
        checkEq("rst_ready",  32'(ready),     32'd1);
        checkEq("rst_vout",   32'(validOut),  32'd0);
        checkEq("rst_result", result,         32'h0);
        checkEq("rst_zero",   32'(zero),      32'd0);
        checkEq("rst_ill",    32'(illegal),   32'd0);
        checkEq("rst_dbz",    32'(divByZero), 32'd0);
        checkEq("rst_hi",     hi,             32'h0);
        checkEq("rst_lo",     lo,             32'h0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] single-cycle ops");
        applyStimulus("slt_neg",  2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
        applyStimulus("slt_pos",  2'b10, 6'b101010, 32'd5,         32'hFFFF_FFFE);
        applyStimulus("lw_add",   2'b00, 6'b000000, 32'd5,         32'd7);
        applyStimulus("beq_sub",  2'b01, 6'b111111, 32'd5,         32'd5);
        applyStimulus("add_wrap", 2'b10, 6'b100000, 32'hFFFF_FFFF, 32'd1);
        applyStimulus("sub_r",    2'b10, 6'b100010, 32'd3,         32'd10);
        applyStimulus("and_r",    2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00);
        applyStimulus("or_r",     2'b10, 6'b100101, 32'hF000_0001, 32'h0000_1230);

        $display("[TB] back-to-back single-cycle ops");
        @(negedge clock);
        aluOp = 2'b10; funct = 6'b100100; a = 32'hFF00_FF00; b = 32'h0FF0_0FF0; validIn = 1'b1;
        e = model(aluOp, funct, a, b); expQ.push_back(e); tagQ.push_back("b2b_and");
        @(posedge clock);
        #1;
        checkOutput(1);
        funct = 6'b100101; a = 32'h0000_00A0; b = 32'h0000_000B;
        e = model(aluOp, funct, a, b); expQ.push_back(e); tagQ.push_back("b2b_or");
        @(posedge clock);
        #1;
        validIn = 1'b0;
        checkOutput(1);

        $display("[TB] multiply");
        applyStimulus("mult",  2'b10, 6'b011000, 32'hFFFF_FFFF, 32'd2);
        applyStimulus("multu", 2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd2);
        applyStimulus("mfhi",  2'b10, 6'b010000, 32'h0,         32'h0);
        applyStimulus("mult_mixed", 2'b10, 6'b011000, 32'h8000_0000, 32'h8000_0000);

        $display("[TB] divide");
        applyStimulus("div_neg",   2'b10, 6'b011010, 32'hFFFF_FFF9, 32'd2);
        applyStimulus("divu_zero", 2'b10, 6'b011011, 32'd7,         32'd0);
        applyStimulus("divu",      2'b10, 6'b011011, 32'd100,       32'd7);
        applyStimulus("div_ovf",   2'b10, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus("mflo",      2'b10, 6'b010010, 32'h0,         32'h0);

        $display("[TB] busy stall and completion-cycle read");
        @(negedge clock);
        aluOp = 2'b10; funct = 6'b011000; a = 32'd3; b = 32'd5; validIn = 1'b1;
        e = model(aluOp, funct, a, b); expQ.push_back(e); tagQ.push_back("busy_mult");
        @(posedge clock);
        #1;
        n = 1;
        @(negedge clock);
        aluOp = 2'b00; funct = 6'h0; a = 32'd1; b = 32'd1;
        checkEq("busy_ready", 32'(ready), 32'd0);
        while (!validOut && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput(n);
        checkEq("done_ready", 32'(ready), 32'd1);
        aluOp = 2'b10; funct = 6'b010010; a = 32'h0; b = 32'h0;
        e = model(aluOp, funct, a, b); expQ.push_back(e); tagQ.push_back("mflo_new");
        @(posedge clock);
        #1;
        validIn = 1'b0;
        n = 1;
        while (!validOut && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput(n);

        $display("[TB] illegal encodings");
        applyStimulus("ill_aluop", 2'b11, 6'b100000, 32'd9, 32'd9);
        applyStimulus("ill_funct", 2'b10, 6'b111111, 32'd9, 32'd9);

        $display("[TB] reset during multiply");
        @(negedge clock);
        aluOp = 2'b10; funct = 6'b011000; a = 32'h0000_1234; b = 32'h0000_0010; validIn = 1'b1;
        @(posedge clock);
        #1;
        validIn = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        mHi = 32'h0;
        mLo = 32'h0;
        mDbz = 1'b0;
        checkEq("abort_ready",  32'(ready),     32'd1);
        checkEq("abort_vout",   32'(validOut),  32'd0);
        checkEq("abort_result", result,         32'h0);
        checkEq("abort_ill",    32'(illegal),   32'd0);
        checkEq("abort_hi",     hi,             32'h0);
        checkEq("abort_lo",     lo,             32'h0);
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (validOut) n++;
        end
        checkEq("abort_no_vout", 32'(n), 32'd0);
        applyStimulus("mflo_after_rst", 2'b10, 6'b010010, 32'h0, 32'h0);
        applyStimulus("add_after_rst",  2'b10, 6'b100000, 32'd40, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
